// File: rtl/vram_pkg.sv
// ---------------------------------------------------------------------------
// vram_pkg
// Shared types and constants for the framebuffer RAM arbiter.
//   vram_tag_t   : identifies who owns a RAM read as it moves down the pipe
//   VRAM_RD_LAT  : request-to-response latency seen by both requesters
//   VRAM_ADDR_W  : default word address width (640x480 words)
//   VRAM_DATA_W  : default pixel word width
// ---------------------------------------------------------------------------
package vram_pkg;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_DISP,
        TAG_HOST
    } vram_tag_t;

    localparam int VRAM_RD_LAT = 3;
    localparam int VRAM_ADDR_W = 19;
    localparam int VRAM_DATA_W = 16;

endpackage

// File: rtl/vram_tag_pipe.sv
// ---------------------------------------------------------------------------
// vram_tag_pipe
// Two-stage shift register carrying the owner tag of each RAM access so that
// the tag leaving the pipe lines up with the RAM read data.
// Ports:
//   clock    : clock
//   reset_n  : asynchronous active-low reset, clears both stages to TAG_NONE
//   tag_in   : tag of the access being registered onto the RAM port
//   tag_out  : tag belonging to the current ram_q
// ---------------------------------------------------------------------------
module vram_tag_pipe
    import vram_pkg::*;
(
    input  logic      clock,
    input  logic      reset_n,
    input  vram_tag_t tag_in,
    output vram_tag_t tag_out
);

    vram_tag_t stage1_q, stage1_d;
    vram_tag_t stage2_q, stage2_d;

    always_comb begin
        stage1_d = tag_in;
        stage2_d = stage1_q;
    end

    // Stage 1 matches the cycle the RAM sees the address, stage 2 the
    // cycle its read data is valid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stage1_q <= TAG_NONE;
            stage2_q <= TAG_NONE;
        end else begin
            stage1_q <= stage1_d;
            stage2_q <= stage2_d;
        end
    end

    assign tag_out = stage2_q;

endmodule

// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
// Single-port framebuffer RAM arbiter. Display reads always win so scanout
// never stalls; host reads/writes use every remaining slot. Both requesters
// see a fixed 3-cycle read latency and accesses complete in issue order.
// Ports:
//   clock, reset_n            : clock and asynchronous active-low reset
//   disp_req/disp_addr        : display read request (one word per cycle)
//   disp_data/disp_valid      : display read response
//   host_req/host_we/host_addr/host_wdata : host command, held until ack
//   host_ack                  : combinational accept of the host command
//   host_rdata/host_rvalid    : host read response
//   host_starved              : host blocked for >= STARVE_LIMIT cycles
//   ram_addr/ram_data/ram_wren: registered RAM port
//   ram_q                     : RAM read data, one cycle after address
// ---------------------------------------------------------------------------
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int          ADDR_W       = VRAM_ADDR_W,
    parameter int          DATA_W       = VRAM_DATA_W,
    parameter logic [15:0] STARVE_LIMIT = 16'd800
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    output logic              host_starved,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    logic              disp_grant;
    logic              host_grant;
    vram_tag_t         issue_tag;
    vram_tag_t         resp_tag;

    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic              ram_wren_q, ram_wren_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;
    logic              disp_valid_q, disp_valid_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic              host_rvalid_q, host_rvalid_d;
    logic [15:0]       starve_cnt_q, starve_cnt_d;
    logic              host_starved_q, host_starved_d;

    // Grant is gated by reset so the host never sees an ack while the
    // datapath is being held in reset.
    assign disp_grant = reset_n & disp_req;
    assign host_grant = reset_n & host_req & ~disp_req;
    assign host_ack   = host_grant;

    // RAM port: an idle cycle keeps the address and write data, only the
    // write enable drops. Writes carry no tag since they produce no response.
    always_comb begin
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_wren_d = 1'b0;
        issue_tag  = TAG_NONE;
        if (disp_grant) begin
            ram_addr_d = disp_addr;
            issue_tag  = TAG_DISP;
        end else if (host_grant) begin
            ram_addr_d = host_addr;
            if (host_we) begin
                ram_data_d = host_wdata;
                ram_wren_d = 1'b1;
            end else begin
                issue_tag = TAG_HOST;
            end
        end
    end

    vram_tag_pipe u_tag_pipe (
        .clock   (clock),
        .reset_n (reset_n),
        .tag_in  (issue_tag),
        .tag_out (resp_tag)
    );

    // Response steering: the tag aligned with ram_q picks which response
    // register captures it; data holds its last value between pulses.
    always_comb begin
        disp_valid_d  = (resp_tag == TAG_DISP);
        host_rvalid_d = (resp_tag == TAG_HOST);
        disp_data_d   = disp_valid_d  ? ram_q : disp_data_q;
        host_rdata_d  = host_rvalid_d ? ram_q : host_rdata_q;
    end

    // Starvation counter: counts consecutive blocked cycles, saturating.
    // The status flag is computed from the next count so it is always
    // consistent with the registered counter value.
    always_comb begin
        starve_cnt_d = 16'd0;
        if (host_req && !host_ack) begin
            starve_cnt_d = (starve_cnt_q == 16'hFFFF) ? starve_cnt_q
                                                      : starve_cnt_q + 16'd1;
        end
        host_starved_d = (starve_cnt_d >= STARVE_LIMIT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr_q     <= '0;
            ram_data_q     <= '0;
            ram_wren_q     <= 1'b0;
            disp_data_q    <= '0;
            disp_valid_q   <= 1'b0;
            host_rdata_q   <= '0;
            host_rvalid_q  <= 1'b0;
            starve_cnt_q   <= 16'd0;
            host_starved_q <= 1'b0;
        end else begin
            ram_addr_q     <= ram_addr_d;
            ram_data_q     <= ram_data_d;
            ram_wren_q     <= ram_wren_d;
            disp_data_q    <= disp_data_d;
            disp_valid_q   <= disp_valid_d;
            host_rdata_q   <= host_rdata_d;
            host_rvalid_q  <= host_rvalid_d;
            starve_cnt_q   <= starve_cnt_d;
            host_starved_q <= host_starved_d;
        end
    end

    assign ram_addr     = ram_addr_q;
    assign ram_data     = ram_data_q;
    assign ram_wren     = ram_wren_q;
    assign disp_data    = disp_data_q;
    assign disp_valid   = disp_valid_q;
    assign host_rdata   = host_rdata_q;
    assign host_rvalid  = host_rvalid_q;
    assign host_starved = host_starved_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_arbiter
// Scoreboard bench for vram_arbiter with a behavioural synchronous RAM.
// Expected read data comes from a shadow copy of memory updated whenever a
// host write is accepted; expected arrival cycle is issue cycle + 3.
// ---------------------------------------------------------------------------
module tb_vram_arbiter;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 16;

    logic              clock = 1'b0;
    logic              reset_n = 1'b1;
    logic              disp_req = 1'b0;
    logic [ADDR_W-1:0] disp_addr = '0;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              host_req = 1'b0;
    logic              host_we = 1'b0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [DATA_W-1:0] host_wdata = '0;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;
    logic              host_starved;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q = '0;

    vram_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (16'd800)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .disp_req     (disp_req),
        .disp_addr    (disp_addr),
        .disp_data    (disp_data),
        .disp_valid   (disp_valid),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_ack     (host_ack),
        .host_rdata   (host_rdata),
        .host_rvalid  (host_rvalid),
        .host_starved (host_starved),
        .ram_addr     (ram_addr),
        .ram_data     (ram_data),
        .ram_wren     (ram_wren),
        .ram_q        (ram_q)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    exp_t disp_sb[$];
    exp_t host_sb[$];

    logic [DATA_W-1:0] shadow [0:1023];
    logic [DATA_W-1:0] mem    [0:1023];

    // Behavioural synchronous RAM: data valid the cycle after the address.
    always @(posedge clock) begin
        if (ram_wren) mem[ram_addr[9:0]] <= ram_data;
        ram_q <= mem[ram_addr[9:0]];
    end

    // Response monitor: a valid pulse is expected exactly when the oldest
    // scoreboard entry falls due; anything else is a gap or a spurious pulse.
    always @(negedge clock) begin
        logic exp_dv;
        logic exp_hv;
        exp_t e;
        exp_dv = 1'b0;
        exp_hv = 1'b0;
        if (disp_sb.size() > 0 && disp_sb[0].due == cyc) begin
            e = disp_sb.pop_front();
            exp_dv = 1'b1;
            n_cmp++;
            if (disp_data !== e.data) begin
                n_fail++;
                $display("[TB] FAIL disp_data cyc %0d: got %h expected %h", cyc, disp_data, e.data);
            end
        end
        n_cmp++;
        if (disp_valid !== exp_dv) begin
            n_fail++;
            $display("[TB] FAIL disp_valid cyc %0d: got %b expected %b", cyc, disp_valid, exp_dv);
        end
        if (host_sb.size() > 0 && host_sb[0].due == cyc) begin
            e = host_sb.pop_front();
            exp_hv = 1'b1;
            n_cmp++;
            if (host_rdata !== e.data) begin
                n_fail++;
                $display("[TB] FAIL host_rdata cyc %0d: got %h expected %h", cyc, host_rdata, e.data);
            end
        end
        n_cmp++;
        if (host_rvalid !== exp_hv) begin
            n_fail++;
            $display("[TB] FAIL host_rvalid cyc %0d: got %b expected %b", cyc, host_rvalid, exp_hv);
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic push_disp(input logic [9:0] a);
        disp_sb.push_back('{data: shadow[a], due: cyc + 3});
    endtask

    task automatic push_host(input logic [9:0] a);
        host_sb.push_back('{data: shadow[a], due: cyc + 3});
    endtask

    task automatic drive_idle();
        disp_req = 1'b0;
        host_req = 1'b0;
        host_we  = 1'b0;
    endtask

    // Reset with both requests active: every output must read 0.
    task automatic test_reset();
        $display("[TB] test_reset");
        disp_req = 1'b1;
        host_req = 1'b1;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        n_cmp++;
        if ({host_ack, ram_wren, disp_valid, host_rvalid, host_starved} !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: got %b expected 00000",
                     {host_ack, ram_wren, disp_valid, host_rvalid, host_starved});
        end
        n_cmp++;
        if (ram_addr !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_ram_addr: got %h expected 0", ram_addr);
        end
        n_cmp++;
        if ({ram_data, disp_data, host_rdata} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_data: got %h/%h/%h expected 0", ram_data, disp_data, host_rdata);
        end
        next_cycle();
        drive_idle();
        reset_n = 1'b1;
    endtask

    // Idle: no write enable, address held, no ack.
    task automatic test_idle(input logic [ADDR_W-1:0] exp_addr);
        $display("[TB] test_idle");
        repeat (10) begin
            next_cycle();
            drive_idle();
            @(negedge clock);
            n_cmp++;
            if (ram_wren !== 1'b0 || host_ack !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL idle_wren_ack: got %b%b expected 00", ram_wren, host_ack);
            end
            n_cmp++;
            if (ram_addr !== exp_addr) begin
                n_fail++;
                $display("[TB] FAIL idle_addr: got %h expected %h", ram_addr, exp_addr);
            end
        end
    endtask

    // Host write followed immediately by a read of the same address.
    task automatic test_write_read();
        $display("[TB] test_write_read");
        next_cycle();
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 19'h00010;
        host_wdata = 16'h0F0F;
        shadow[10'h010] = 16'h0F0F;
        @(negedge clock);
        n_cmp++;
        if (host_ack !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL wr_ack: got %b expected 1", host_ack);
        end
        next_cycle();
        host_we = 1'b0;
        push_host(10'h010);
        @(negedge clock);
        n_cmp++;
        if (host_ack !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rd_ack: got %b expected 1", host_ack);
        end
        n_cmp++;
        if ({ram_wren, ram_addr, ram_data} !== {1'b1, 19'h00010, 16'h0F0F}) begin
            n_fail++;
            $display("[TB] FAIL wr_port: got %b %h %h expected 1 00010 0f0f", ram_wren, ram_addr, ram_data);
        end
        next_cycle();
        drive_idle();
        @(negedge clock);
        n_cmp++;
        if (ram_wren !== 1'b0 || ram_addr !== 19'h00010) begin
            n_fail++;
            $display("[TB] FAIL rd_port: got %b %h expected 0 00010", ram_wren, ram_addr);
        end
        repeat (4) next_cycle();
    endtask

    // Fill addresses 0..639 with addr+1 through the host port.
    task automatic test_host_write_burst();
        $display("[TB] test_host_write_burst");
        for (int i = 0; i < 640; i++) begin
            next_cycle();
            host_req   = 1'b1;
            host_we    = 1'b1;
            host_addr  = 19'(i);
            host_wdata = 16'(i + 1);
            shadow[i]  = 16'(i + 1);
            @(negedge clock);
            n_cmp++;
            if (host_ack !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL burst_ack %0d: got %b expected 1", i, host_ack);
            end
        end
        next_cycle();
        drive_idle();
        repeat (2) next_cycle();
    endtask

    // One full scanline of back-to-back display reads.
    task automatic test_back_to_back();
        $display("[TB] test_back_to_back");
        for (int i = 0; i < 640; i++) begin
            next_cycle();
            disp_req  = 1'b1;
            disp_addr = 19'(i);
            push_disp(10'(i));
        end
        next_cycle();
        drive_idle();
        repeat (4) next_cycle();
    endtask

    // Host blocked by 5 display reads, accepted on the 6th cycle.
    task automatic test_contention();
        $display("[TB] test_contention");
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            disp_req  = 1'b1;
            disp_addr = 19'(100 + k);
            host_req  = 1'b1;
            host_we   = 1'b0;
            host_addr = 19'h00020;
            push_disp(10'(100 + k));
            @(negedge clock);
            n_cmp++;
            if (host_ack !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL cont_ack_blocked %0d: got %b expected 0", k, host_ack);
            end
        end
        next_cycle();
        disp_req = 1'b0;
        push_host(10'h020);
        @(negedge clock);
        n_cmp++;
        if (host_ack !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL cont_ack_free: got %b expected 1", host_ack);
        end
        next_cycle();
        drive_idle();
        repeat (4) next_cycle();
    endtask

    // 800 blocked cycles: starved rises after the 800th, falls after ack.
    task automatic test_starvation();
        logic exp_st;
        $display("[TB] test_starvation");
        for (int k = 1; k <= 800; k++) begin
            next_cycle();
            disp_req  = 1'b1;
            disp_addr = 19'(k % 640);
            host_req  = 1'b1;
            host_we   = 1'b0;
            host_addr = 19'h00030;
            push_disp(10'(k % 640));
            @(negedge clock);
            exp_st = ((k - 1) >= 800);
            n_cmp++;
            if (host_ack !== 1'b0 || host_starved !== exp_st) begin
                n_fail++;
                $display("[TB] FAIL starve_blocked %0d: got ack %b st %b expected ack 0 st %b",
                         k, host_ack, host_starved, exp_st);
            end
        end
        next_cycle();
        disp_req = 1'b0;
        push_host(10'h030);
        @(negedge clock);
        n_cmp++;
        if (host_ack !== 1'b1 || host_starved !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL starve_rise: got ack %b st %b expected ack 1 st 1", host_ack, host_starved);
        end
        next_cycle();
        drive_idle();
        @(negedge clock);
        n_cmp++;
        if (host_starved !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL starve_fall: got %b expected 0", host_starved);
        end
        repeat (4) next_cycle();
    endtask

    // Reset while a display read and a host read are in flight.
    task automatic test_reset_mid();
        $display("[TB] test_reset_mid");
        next_cycle();
        disp_req  = 1'b1;
        disp_addr = 19'd7;
        next_cycle();
        disp_req  = 1'b0;
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 19'd8;
        next_cycle();
        reset_n = 1'b0;
        disp_sb.delete();
        host_sb.delete();
        @(negedge clock);
        n_cmp++;
        if ({host_ack, ram_wren, disp_valid, host_rvalid, host_starved} !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL midrst_ctrl: got %b expected 00000",
                     {host_ack, ram_wren, disp_valid, host_rvalid, host_starved});
        end
        n_cmp++;
        if (ram_addr !== '0 || {ram_data, disp_data, host_rdata} !== '0) begin
            n_fail++;
            $display("[TB] FAIL midrst_data: got %h %h %h %h expected 0",
                     ram_addr, ram_data, disp_data, host_rdata);
        end
        next_cycle();
        drive_idle();
        reset_n = 1'b1;
        repeat (6) begin
            next_cycle();
            @(negedge clock);
            n_cmp++;
            if (disp_valid !== 1'b0 || host_rvalid !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL midrst_valid: got %b%b expected 00", disp_valid, host_rvalid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle(19'h0);
        test_write_read();
        test_idle(19'h00010);
        test_host_write_burst();
        test_back_to_back();
        test_contention();
        test_starvation();
        test_reset_mid();
        n_cmp++;
        if (disp_sb.size() != 0 || host_sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL sb_drain: got %0d/%0d pending expected 0/0", disp_sb.size(), host_sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
